// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture controller.
package cam_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // The camera sends the high byte first; the pixel is {first, second}.
  function automatic rgb565_t to_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/camera_capture_ctrl_sync_edge.sv
// N-stage synchronizer for an asynchronous level, plus a one-cycle pulse
// on the rising edge of the synchronized level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async level through the synchronizer and keep the last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/camera_capture_ctrl.sv
// Frame capture sequencer: arms on a shutter press (or free-runs), aligns to
// the vsync falling edge, pairs bytes into RGB565 pixels with x/y, and flags
// frame geometry errors. Handshake: pix_valid is a one-cycle strobe with
// pix_data/pix_x/pix_y valid in the same cycle; there is no ready, so the
// consumer must take every strobe.
module camera_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cam_href,
  input  logic                        cam_vsync,
  input  logic [7:0]                  cam_data,
  input  logic                        shutter_sw,
  input  logic                        continuous,
  output logic                        pix_valid,
  output logic [15:0]                 pix_data,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        geom_err
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  // Per-line pixel and per-frame line counts saturate one past nominal so
  // that both "short" and "long" are distinguishable from exact.
  localparam int LPW = $clog2(H_ACTIVE + 2);
  localparam int LNW = $clog2(V_ACTIVE + 2);

  cap_state_e       state_q, state_d;
  logic             href_r_q, vsync_r_q, href_p_q, vsync_p_q;
  logic [7:0]       data_r_q;
  logic             press;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [XW-1:0]    x_cnt_q, x_cnt_d, pix_x_q, pix_x_d;
  logic [YW-1:0]    y_cnt_q, y_cnt_d, pix_y_q, pix_y_d;
  logic [LPW-1:0]   line_pix_q, line_pix_d;
  logic [LNW-1:0]   lines_q, lines_d, lines_eff;
  logic             pix_valid_q, pix_valid_d;
  rgb565_t          pix_q, pix_d;
  logic             err_q, err_d;
  logic             fstart_q, fstart_d;
  logic             vsync_fall, vsync_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_shutter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .async_i(shutter_sw),
    .rise_o (press)
  );

  assign vsync_fall = ~vsync_r_q & vsync_p_q;
  assign vsync_rise = vsync_r_q & ~vsync_p_q;

  // Register the camera bus once and keep the previous copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      href_r_q  <= 1'b0;
      vsync_r_q <= 1'b0;
      data_r_q  <= '0;
      href_p_q  <= 1'b0;
      vsync_p_q <= 1'b0;
    end else begin
      href_r_q  <= cam_href;
      vsync_r_q <= cam_vsync;
      data_r_q  <= cam_data;
      href_p_q  <= href_r_q;
      vsync_p_q <= vsync_r_q;
    end
  end

  // Capture sequencing; a fall is only seen after a rise, so arming while
  // vsync is already low waits for the next full blanking interval.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (press || continuous) state_d = ARM;
      ARM:     if (vsync_fall)          state_d = CAPTURE;
      CAPTURE: if (vsync_rise)          state_d = DONE;
      DONE:    state_d = continuous ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte pairing, coordinate counters and geometry checking.
  always_comb begin
    phase_d     = phase_q;
    hi_d        = hi_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    line_pix_d  = line_pix_q;
    lines_d     = lines_q;
    lines_eff   = lines_q;
    pix_valid_d = 1'b0;
    pix_d       = pix_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    err_d       = err_q;
    fstart_d    = 1'b0;
    if (state_q != ARM && state_d == ARM) err_d = 1'b0;
    if (state_q == ARM && vsync_fall) begin
      fstart_d   = 1'b1;
      phase_d    = 1'b0;
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      line_pix_d = '0;
      lines_d    = '0;
    end
    if (state_q == CAPTURE) begin
      if (href_r_q) begin
        if (vsync_r_q) err_d = 1'b1;
        if (!phase_q) begin
          hi_d    = data_r_q;
          phase_d = 1'b1;
        end else begin
          phase_d     = 1'b0;
          pix_valid_d = 1'b1;
          pix_d       = to_rgb565(hi_q, data_r_q);
          pix_x_d     = x_cnt_q;
          pix_y_d     = y_cnt_q;
          if (x_cnt_q != XW'(H_ACTIVE - 1))    x_cnt_d    = x_cnt_q + 1'b1;
          if (line_pix_q != LPW'(H_ACTIVE + 1)) line_pix_d = line_pix_q + 1'b1;
        end
      end else if (href_p_q) begin
        // Line end: an odd phase means a dangling byte, which is dropped.
        if (phase_q || line_pix_q != LPW'(H_ACTIVE)) err_d = 1'b1;
        phase_d    = 1'b0;
        x_cnt_d    = '0;
        line_pix_d = '0;
        if (y_cnt_q != YW'(V_ACTIVE - 1)) y_cnt_d = y_cnt_q + 1'b1;
        if (lines_q != LNW'(V_ACTIVE + 1)) lines_eff = lines_q + 1'b1;
        lines_d = lines_eff;
      end
      // A line ending in the same cycle as the vsync rise is counted first.
      if (vsync_rise && lines_eff != LNW'(V_ACTIVE)) err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      line_pix_q  <= '0;
      lines_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      err_q       <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      line_pix_q  <= line_pix_d;
      lines_q     <= lines_d;
      pix_valid_q <= pix_valid_d;
      pix_q       <= pix_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      err_q       <= err_d;
      fstart_q    <= fstart_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fstart_q;
  assign frame_done  = (state_q == DONE);
  assign busy        = (state_q == ARM) || (state_q == CAPTURE);
  assign geom_err    = err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed-sequence bench with random bytes/gaps; expected pixels come from a
// frame-level model (byte pairs, saturated coordinates, geometry rule).
module tb_camera_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int EW = 16 + XW + YW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cam_href, cam_vsync, shutter_sw, continuous;
  logic [7:0]    cam_data;
  logic          pix_valid, frame_start, frame_done, busy, geom_err;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  int tests = 0;
  int fails = 0;
  int fs_cnt = 0, fd_cnt = 0, pix_cnt = 0;
  int fs0, fd0, pc0;

  logic [EW-1:0] exp_q[$];
  int            n_lines;
  int            line_len[8];
  logic [7:0]    line_bytes[8][16];

  camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .shutter_sw(shutter_sw), .continuous(continuous),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .geom_err(geom_err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard: every pixel strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (frame_done)  fd_cnt++;
    if (pix_valid) begin
      pix_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_pix got=%h x=%0d y=%0d exp=none", pix_data, pix_x, pix_y);
      end
      if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        assert ({pix_data, pix_x, pix_y} === e) else begin
          fails++;
          $error("FAIL pix got=%h/%0d/%0d exp=%h/%0d/%0d", pix_data, pix_x, pix_y,
                 e[EW-1:EW-16], e[XW+YW-1:YW], e[YW-1:0]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 0);
    check({tag, "_data"},  32'(pix_data), 0);
    check({tag, "_x"},     32'(pix_x), 0);
    check({tag, "_y"},     32'(pix_y), 0);
    check({tag, "_fs"},    32'(frame_start), 0);
    check({tag, "_fd"},    32'(frame_done), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_err"},   32'(geom_err), 0);
  endtask

  // Frame builder: nl lines of 2*H bytes, one optional odd-length line.
  task automatic build(input int nl, input int bad_line, input int bad_len, input bit seq);
    n_lines = nl;
    for (int l = 0; l < nl; l++) begin
      line_len[l] = (l == bad_line) ? bad_len : 2 * H;
      for (int i = 0; i < line_len[l]; i++)
        line_bytes[l][i] = seq ? 8'(l * 2 * H + i) : 8'($urandom_range(0, 255));
    end
  endtask

  // Reference model: pixels are byte pairs of each line, coordinates saturate.
  function automatic void push_expected(input int upto);
    for (int l = 0; l < n_lines && l < upto; l++)
      for (int p = 0; p < line_len[l] / 2; p++) begin
        int xi, yi;
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        xi = (p < H) ? p : H - 1;
        yi = (l < V) ? l : V - 1;
        xv = xi[XW-1:0];
        yv = yi[YW-1:0];
        exp_q.push_back({line_bytes[l][2*p], line_bytes[l][2*p+1], xv, yv});
      end
  endfunction

  function automatic logic model_err();
    if (n_lines != V) return 1'b1;
    for (int l = 0; l < n_lines; l++)
      if (line_len[l] != 2 * H) return 1'b1;
    return 1'b0;
  endfunction

  task automatic press();
    shutter_sw = 1'b1;
    repeat (4) @(negedge clk);
    shutter_sw = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Drive one frame; optional press, continuous drop or reset during a line.
  task automatic drive_frame(input int press_line, input int drop_line, input int rst_line);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    cam_vsync = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    for (int l = 0; l < n_lines; l++) begin
      if (l == press_line) shutter_sw = 1'b1;
      if (l == drop_line)  continuous = 1'b0;
      for (int i = 0; i < line_len[l]; i++) begin
        cam_href = 1'b1;
        cam_data = line_bytes[l][i];
        if (l == rst_line && i == 0) begin
          reset_n = 1'b0;
          #1;
          check_all_zero("rst_mid");
        end
        @(negedge clk);
        reset_n = 1'b1;
      end
      cam_href   = 1'b0;
      cam_data   = 8'h00;
      shutter_sw = 1'b0;
      repeat ($urandom_range(3, 5)) @(negedge clk);
    end
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    reset_n = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_data = 8'h00;
    shutter_sw = 1'b0; continuous = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: clean single-shot frame of bytes 0x00..0x17
    press();
    check("t1_armed", 32'(busy), 1);
    fs0 = fs_cnt; fd0 = fd_cnt; pc0 = pix_cnt;
    build(3, -1, 0, 1'b1);
    push_expected(99);
    drive_frame(-1, -1, -1);
    settle("t1");
    check("t1_fs", 32'(fs_cnt - fs0), 1);
    check("t1_fd", 32'(fd_cnt - fd0), 1);
    check("t1_pix", 32'(pix_cnt - pc0), 12);
    check("t1_err", 32'(geom_err), 0);
    check("t1_idle", 32'(busy), 0);

    // 2: press mid-frame; that frame is skipped, the next one captured
    fs0 = fs_cnt;
    build(3, -1, 0, 1'b0);
    drive_frame(1, -1, -1);
    check("t2_armed", 32'(busy), 1);
    check("t2_no_fs", 32'(fs_cnt - fs0), 0);
    build(3, -1, 0, 1'b0);
    push_expected(99);
    drive_frame(-1, -1, -1);
    settle("t2");
    check("t2_fs", 32'(fs_cnt - fs0), 1);
    check("t2_err", 32'(geom_err), 0);
    check("t2_idle", 32'(busy), 0);

    // 3: 7-byte line -> 3 pixels, sticky error until next arm
    press();
    build(3, 1, 7, 1'b0);
    push_expected(99);
    drive_frame(-1, -1, -1);
    settle("t3");
    check("t3_err", 32'(geom_err), 32'(model_err()));
    repeat (10) @(negedge clk);
    check("t3_err_held", 32'(geom_err), 1);
    press();
    check("t3_err_clr", 32'(geom_err), 0);
    build(3, -1, 0, 1'b0);
    push_expected(99);
    drive_frame(-1, -1, -1);
    settle("t3b");
    check("t3b_err", 32'(geom_err), 0);

    // 4: continuous mode, then drop continuous mid-frame
    continuous = 1'b1;
    fs0 = fs_cnt; fd0 = fd_cnt; pc0 = pix_cnt;
    for (int f = 0; f < 3; f++) begin
      build(3, -1, 0, 1'b0);
      push_expected(99);
      drive_frame(-1, -1, -1);
    end
    settle("t4");
    check("t4_fs", 32'(fs_cnt - fs0), 3);
    check("t4_fd", 32'(fd_cnt - fd0), 3);
    check("t4_pix", 32'(pix_cnt - pc0), 36);
    build(3, -1, 0, 1'b0);
    push_expected(99);
    drive_frame(-1, 1, -1);
    build(3, -1, 0, 1'b0);
    drive_frame(-1, -1, -1);
    settle("t4b");
    check("t4b_fs", 32'(fs_cnt - fs0), 4);
    check("t4b_fd", 32'(fd_cnt - fd0), 4);
    check("t4b_idle", 32'(busy), 0);

    // 5: extra line saturates y; press during capture ignored
    press();
    fs0 = fs_cnt;
    build(4, -1, 0, 1'b0);
    push_expected(99);
    drive_frame(1, -1, -1);
    settle("t5");
    check("t5_err", 32'(geom_err), 32'(model_err()));
    check("t5_idle", 32'(busy), 0);
    build(3, -1, 0, 1'b0);
    drive_frame(-1, -1, -1);
    settle("t5b");
    check("t5_fs", 32'(fs_cnt - fs0), 1);

    // 6: one-cycle reset at the start of line 1
    press();
    build(3, -1, 0, 1'b0);
    push_expected(1);
    drive_frame(-1, -1, 1);
    settle("t6");
    check("t6_idle", 32'(busy), 0);
    fs0 = fs_cnt;
    build(3, -1, 0, 1'b0);
    drive_frame(-1, -1, -1);
    settle("t6b");
    check("t6_no_fs", 32'(fs_cnt - fs0), 0);
    press();
    build(3, -1, 0, 1'b0);
    push_expected(99);
    drive_frame(-1, -1, -1);
    settle("t6c");
    check("t6c_fs", 32'(fs_cnt - fs0), 1);
    check("t6c_err", 32'(geom_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
